// File: rtl/xpmwrap_pkg.sv
// Shared types and limits for the byte-write dual-port distributed RAM wrapper.
package xpmwrap_pkg;

  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 3;

  // Controller states; CLEAR is the reset state so the array is zeroed first.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } xpm_state_e;

endpackage : xpmwrap_pkg

// File: rtl/xpmwrap_rd_pipe.sv
// Read-data pipeline: LATENCY stages of data+valid. The inner stages always
// shift; only the last stage honours regce so the consumer can stall the
// visible output without freezing the rest of the pipe.
module xpmwrap_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  regce,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out
);

  localparam int LAST = LATENCY - 1;

  logic [DATA_WIDTH-1:0] data_q   [LATENCY];
  logic [DATA_WIDTH-1:0] data_d   [LATENCY];
  logic [DATA_WIDTH-1:0] data_src [LATENCY];
  logic [LATENCY-1:0]    valid_q;
  logic [LATENCY-1:0]    valid_d;
  logic [LATENCY-1:0]    valid_src;

  // Source of each stage: the pipe input for stage 0, the previous stage otherwise.
  always_comb begin
    data_src[0]  = data_in;
    valid_src    = '0;
    valid_src[0] = valid_in;
    for (int i = 1; i < LATENCY; i++) begin
      data_src[i]  = data_q[i-1];
      valid_src[i] = valid_q[i-1];
    end
  end

  // Inner stages advance every cycle; the last stage loads only when regce is high.
  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
      data_d[i]  = data_q[i];
      valid_d[i] = valid_q[i];
      if ((i != LAST) || regce) begin
        data_d[i]  = data_src[i];
        valid_d[i] = valid_src[i];
      end
    end
  end

  // Stage registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q[LAST];
  assign valid_out = valid_q[LAST];

endmodule : xpmwrap_rd_pipe

// File: rtl/xpmwrap_dpdistram_bw_init.sv
// Dual-port distributed RAM with byte-lane writes on port A, read-only port B,
// and a hardware clear sequencer that zeroes the array after reset or on request.
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | writing zero to addr_cnt, one word per cycle; user ports masked
// IDLE  | normal operation; init_req starts a new clear
module xpmwrap_dpdistram_bw_init
  import xpmwrap_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 2,
  parameter int COLLISION_MODE = 0
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             init_req,
  output logic                             init_busy,
  input  logic                             ena,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]            addra,
  input  logic [DATA_WIDTH-1:0]            dina,
  input  logic                             regcea,
  output logic [DATA_WIDTH-1:0]            douta,
  output logic                             douta_valid,
  input  logic                             enb,
  input  logic [ADDR_WIDTH-1:0]            addrb,
  input  logic                             regceb,
  output logic [DATA_WIDTH-1:0]            doutb,
  output logic                             doutb_valid
);

  localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_byte_width
    $error("DATA_WIDTH must be an integer multiple of BYTE_WIDTH");
  end
  if ((READ_LATENCY < MIN_READ_LATENCY) || (READ_LATENCY > MAX_READ_LATENCY)) begin : g_bad_latency
    $error("READ_LATENCY must lie within 1..3");
  end
  if ((COLLISION_MODE != 0) && (COLLISION_MODE != 1)) begin : g_bad_collision
    $error("COLLISION_MODE must be 0 or 1");
  end

  xpm_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;

  logic                  user_en_a;
  logic                  user_en_b;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [NUM_LANES-1:0]  ram_wmask;

  logic [DATA_WIDTH-1:0] ram_mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;
  logic [DATA_WIDTH-1:0] pipe_in_a;
  logic [DATA_WIDTH-1:0] pipe_in_b;

  // State and clear-address registers; reset lands in CLEAR at address 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= CLEAR;
      addr_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
    end
  end

  // Next state: a clear runs to the last address and cannot be restarted by init_req.
  always_comb begin
    state_d    = state_q;
    addr_cnt_d = '0;
    unique case (state_q)
      CLEAR: begin
        addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
        if (addr_cnt_q == LAST_ADDR) begin
          state_d    = IDLE;
          addr_cnt_d = '0;
        end
      end
      IDLE: begin
        if (init_req) begin
          state_d = CLEAR;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Outputs: the clear owns the write port and masks both user enables.
  always_comb begin
    init_busy = (state_q == CLEAR);
    user_en_a = ena && (state_q == IDLE);
    user_en_b = enb && (state_q == IDLE);
    if (state_q == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = addr_cnt_q;
      ram_wdata = '0;
      ram_wmask = '1;
    end else begin
      ram_we    = user_en_a && (|wea);
      ram_waddr = addra;
      ram_wdata = dina;
      ram_wmask = wea;
    end
  end

  // Array write, one enable per byte lane; the array itself has no reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (ram_wmask[i]) begin
          ram_mem[ram_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= ram_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Asynchronous reads; port A is read-first because the array updates at the same edge.
  // Port B optionally forwards the lanes port A is writing to the same address.
  always_comb begin
    rd_a = ram_mem[addra];
    rd_b = ram_mem[addrb];
    if ((COLLISION_MODE == 1) && user_en_a && (addra == addrb)) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wea[i]) begin
          rd_b[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Unissued slots carry zero so an idle pipe presents a clean, deterministic word.
  always_comb begin
    pipe_in_a = user_en_a ? rd_a : '0;
    pipe_in_b = user_en_b ? rd_b : '0;
  end

  xpmwrap_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_pipe_a (
    .clk       (clk),
    .rstn      (rstn),
    .valid_in  (user_en_a),
    .data_in   (pipe_in_a),
    .regce     (regcea),
    .data_out  (douta),
    .valid_out (douta_valid)
  );

  xpmwrap_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_pipe_b (
    .clk       (clk),
    .rstn      (rstn),
    .valid_in  (user_en_b),
    .data_in   (pipe_in_b),
    .regce     (regceb),
    .data_out  (doutb),
    .valid_out (doutb_valid)
  );

endmodule : xpmwrap_dpdistram_bw_init

// File: tb/tb_xpmwrap_dpdistram_bw_init.sv
// Bench for the byte-write dual-port RAM wrapper. Four instances with different
// latency/collision settings share one stimulus stream; a reference model of
// the memory and of per-op issue records predicts every instance's outputs.
module tb_xpmwrap_dpdistram_bw_init;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        init_req = 1'b0;
  logic        ena = 1'b0;
  logic [3:0]  wea = '0;
  logic [5:0]  addra = '0;
  logic [31:0] dina = '0;
  logic        regcea = 1'b1;
  logic        enb = 1'b0;
  logic [5:0]  addrb = '0;
  logic        regceb = 1'b1;

  logic        busy_w   [4];
  logic [31:0] douta_w  [4];
  logic        douta_vw [4];
  logic [31:0] doutb_w  [4];
  logic        doutb_vw [4];

  int rl_of [4] = '{2, 2, 1, 3};
  int cm_of [4] = '{0, 1, 0, 1};

  int total = 0;
  int bad   = 0;

  // reference model
  logic [31:0] m_mem [64];
  int          busy_left;
  int          ecount;
  logic        h_av  [4];
  logic [31:0] h_ad  [4];
  logic        h_bv  [4];
  logic [31:0] h_bd0 [4];
  logic [31:0] h_bd1 [4];
  logic        e_av [4];
  logic [31:0] e_ad [4];
  logic        e_bv [4];
  logic [31:0] e_bd [4];

  always #5 clk = ~clk;

  xpmwrap_dpdistram_bw_init #(.READ_LATENCY(2), .COLLISION_MODE(0)) u_r2c0 (
    .clk(clk), .rstn(rstn), .init_req(init_req), .init_busy(busy_w[0]),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .regcea(regcea),
    .douta(douta_w[0]), .douta_valid(douta_vw[0]),
    .enb(enb), .addrb(addrb), .regceb(regceb),
    .doutb(doutb_w[0]), .doutb_valid(doutb_vw[0]));

  xpmwrap_dpdistram_bw_init #(.READ_LATENCY(2), .COLLISION_MODE(1)) u_r2c1 (
    .clk(clk), .rstn(rstn), .init_req(init_req), .init_busy(busy_w[1]),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .regcea(regcea),
    .douta(douta_w[1]), .douta_valid(douta_vw[1]),
    .enb(enb), .addrb(addrb), .regceb(regceb),
    .doutb(doutb_w[1]), .doutb_valid(doutb_vw[1]));

  xpmwrap_dpdistram_bw_init #(.READ_LATENCY(1), .COLLISION_MODE(0)) u_r1c0 (
    .clk(clk), .rstn(rstn), .init_req(init_req), .init_busy(busy_w[2]),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .regcea(regcea),
    .douta(douta_w[2]), .douta_valid(douta_vw[2]),
    .enb(enb), .addrb(addrb), .regceb(regceb),
    .doutb(doutb_w[2]), .doutb_valid(doutb_vw[2]));

  xpmwrap_dpdistram_bw_init #(.READ_LATENCY(3), .COLLISION_MODE(1)) u_r3c1 (
    .clk(clk), .rstn(rstn), .init_req(init_req), .init_busy(busy_w[3]),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .regcea(regcea),
    .douta(douta_w[3]), .douta_valid(douta_vw[3]),
    .enb(enb), .addrb(addrb), .regceb(regceb),
    .doutb(doutb_w[3]), .doutb_valid(doutb_vw[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy_left = 64;
    for (int i = 0; i < 4; i++) begin
      h_av[i] = 1'b0; h_ad[i] = '0; h_bv[i] = 1'b0; h_bd0[i] = '0; h_bd1[i] = '0;
      e_av[i] = 1'b0; e_ad[i] = '0; e_bv[i] = 1'b0; e_bd[i] = '0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("busy[%0d]", k), 32'(busy_w[k]), 32'(busy_left > 0));
      check($sformatf("douta[%0d]", k), douta_w[k], e_ad[k]);
      check($sformatf("douta_valid[%0d]", k), 32'(douta_vw[k]), 32'(e_av[k]));
      check($sformatf("doutb[%0d]", k), doutb_w[k], e_bd[k]);
      check($sformatf("doutb_valid[%0d]", k), 32'(doutb_vw[k]), 32'(e_bv[k]));
    end
  endtask

  // Apply one clock edge to the model using the current inputs, then compare.
  task automatic tick();
    logic av, bv;
    logic [31:0] ad, bd0, bd1;
    int cur, src;
    av = 1'b0; bv = 1'b0; ad = '0; bd0 = '0; bd1 = '0;
    if (rstn) begin
      if (busy_left > 0) begin
        m_mem[64 - busy_left] = '0;
        busy_left--;
      end else begin
        if (ena) begin
          av = 1'b1;
          ad = m_mem[addra];
        end
        if (enb) begin
          bv  = 1'b1;
          bd0 = m_mem[addrb];
          bd1 = bd0;
          if (ena && (addra == addrb))
            for (int l = 0; l < 4; l++) if (wea[l]) bd1[l*8 +: 8] = dina[l*8 +: 8];
        end
        if (ena)
          for (int l = 0; l < 4; l++) if (wea[l]) m_mem[addra][l*8 +: 8] = dina[l*8 +: 8];
        if (init_req) busy_left = 64;
      end
      cur = ecount;
      h_av[cur % 4] = av; h_ad[cur % 4] = ad;
      h_bv[cur % 4] = bv; h_bd0[cur % 4] = bd0; h_bd1[cur % 4] = bd1;
      for (int k = 0; k < 4; k++) begin
        src = (cur - (rl_of[k] - 1)) % 4;
        if (regcea) begin e_av[k] = h_av[src]; e_ad[k] = h_ad[src]; end
        if (regceb) begin
          e_bv[k] = h_bv[src];
          e_bd[k] = (cm_of[k] == 1) ? h_bd1[src] : h_bd0[src];
        end
      end
      ecount++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic assert_reset();
    rstn = 1'b0;
    model_reset();
    #1;
    check_all();
  endtask

  initial begin
    int n, busy_cycles, valids, first_seen[4];
    logic [31:0] acc;
    ecount = 8;
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    model_reset();

    // reset state
    #2;
    assert_reset();
    repeat (3) tick();
    rstn = 1'b1;
    check("busy_at_release", 32'(busy_w[0]), 32'd1);

    // post-reset clear length
    busy_cycles = 0;
    while (busy_w[0] && busy_cycles < 200) begin
      tick();
      busy_cycles++;
    end
    check("clear_cycles", busy_cycles, 64);

    // port B sweep of the cleared array
    for (int a = 0; a < 64; a++) begin
      enb = 1'b1; addrb = 6'(a);
      tick();
    end
    enb = 1'b0;
    repeat (3) tick();

    // byte-lane write then partial write, read back on port A
    ena = 1'b1; addra = 6'd5; wea = 4'b1111; dina = 32'hAABBCCDD;
    tick();
    wea = 4'b0010; dina = 32'h11223344;
    tick();
    wea = 4'b0000;
    tick();
    ena = 1'b0;
    tick();
    check("bytelane_read", douta_w[0], 32'hAABB33DD);
    tick();

    // same-address collision between port A write and port B read
    ena = 1'b1; addra = 6'd9; wea = 4'b0001; dina = 32'hFFFFFFFF;
    enb = 1'b1; addrb = 6'd9;
    tick();
    ena = 1'b0; enb = 1'b0; wea = '0;
    tick();
    check("collision_mode0", doutb_w[0], 32'h00000000);
    check("collision_mode1", doutb_w[1], 32'h000000FF);
    repeat (3) tick();

    // regceb stall holds the visible word; new word lands once regceb returns
    enb = 1'b1; addrb = 6'd5;
    tick();
    addrb = 6'd9;
    tick();
    check("regce_before", doutb_w[0], 32'hAABB33DD);
    regceb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("regce_hold_data", doutb_w[0], 32'hAABB33DD);
      check("regce_hold_valid", 32'(doutb_vw[0]), 32'd1);
    end
    regceb = 1'b1; enb = 1'b0;
    tick();
    check("regce_release", doutb_w[0], 32'h000000FF);
    repeat (3) tick();

    // randomized traffic, including collisions, regce stalls and rare clears
    for (int i = 0; i < 300; i++) begin
      ena    = ($urandom_range(0, 2) != 0);
      wea    = 4'($urandom);
      addra  = 6'($urandom);
      dina   = $urandom;
      enb    = ($urandom_range(0, 2) != 0);
      addrb  = ($urandom_range(0, 3) == 0) ? addra : 6'($urandom);
      regcea = ($urandom_range(0, 7) != 0);
      regceb = ($urandom_range(0, 7) != 0);
      init_req = ($urandom_range(0, 79) == 0);
      tick();
    end
    ena = 1'b0; enb = 1'b0; init_req = 1'b0; regcea = 1'b1; regceb = 1'b1; wea = '0;
    n = 0;
    while (busy_w[0] && n < 200) begin
      tick();
      n++;
    end
    check("idle_before_reclear", 32'(busy_w[0]), 32'd0);

    // nonzero content, then clear interrupted by reset at counter 20
    ena = 1'b1; addra = 6'd20; wea = 4'hF; dina = 32'h12345678;
    tick();
    ena = 1'b0; wea = '0;
    repeat (4) tick();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    n = 0;
    while ((64 - busy_left) != 20 && n < 100) begin
      ena = ~ena; addra = 6'($urandom); wea = 4'($urandom); dina = $urandom;
      init_req = ena;
      tick();
      if (n >= 4) check("clear_no_valid", 32'(douta_vw[0]), 32'd0);
      n++;
    end
    check("clear_counter_20", 64 - busy_left, 20);
    ena = 1'b0; init_req = 1'b0; wea = '0;
    assert_reset();
    repeat (2) tick();
    rstn = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ena = i[0]; addra = 6'($urandom); wea = 4'hF; dina = 32'hDEADBEEF;
      tick();
      check("reclear_no_valid", 32'(douta_vw[0]), 32'd0);
    end
    ena = 1'b0; wea = '0;
    check("reclear_done", 32'(busy_w[0]), 32'd0);

    // every word reads zero after the restarted clear
    acc = '0; valids = 0;
    for (int a = 0; a < 67; a++) begin
      ena = (a < 64); addra = 6'(a);
      enb = (a < 64); addrb = 6'(63 - (a % 64));
      tick();
      if (douta_vw[0]) begin
        valids++;
        acc |= douta_w[0];
      end
    end
    ena = 1'b0; enb = 1'b0;
    check("reclear_all_zero", acc, 32'h0);
    check("reclear_read_count", valids, 64);
    repeat (3) tick();

    // enable-to-valid latency per instance
    for (int k = 0; k < 4; k++) first_seen[k] = 0;
    ena = 1'b1; addra = 6'd20;
    for (int e = 1; e <= 6; e++) begin
      tick();
      ena = 1'b0;
      for (int k = 0; k < 4; k++) if (first_seen[k] == 0 && douta_vw[k]) first_seen[k] = e;
    end
    for (int k = 0; k < 4; k++) check($sformatf("latency[%0d]", k), first_seen[k], rl_of[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_xpmwrap_dpdistram_bw_init
